// File: rtl/sequence_checker.sv
// Receive-side checker for the SequenceGenerator byte stream.
// Hunts for AF, confirms alignment, then flags per-byte match/error.
module sequence_checker #(
  parameter int LOCK_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [7:0]       data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             match,
  output logic             error,
  output logic             seq_done,
  output logic [7:0]       expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] seq_count
);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  localparam logic [2:0] LOCK_RUN = 3'(LOCK_LEN);

  function automatic logic [7:0] seq_byte(input logic [2:0] i);
    logic [7:0] b;
    unique case (i)
      3'd0:    b = 8'hAF;
      3'd1:    b = 8'hBC;
      3'd2:    b = 8'hE2;
      3'd3:    b = 8'h78;
      3'd4:    b = 8'hFF;
      3'd5:    b = 8'h0B;
      3'd6:    b = 8'h8D;
      default: b = 8'hAF;
    endcase
    return b;
  endfunction

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [2:0] run, run_n;
  logic [2:0] idx_inc;
  logic [2:0] run_inc;
  logic       hit, is_af;
  logic       match_n, error_n, seq_done_n;

  always_comb begin
    idx_inc = (idx == 3'd6) ? 3'd0 : 3'(idx + 3'd1);
    run_inc = 3'(run + 3'd1);
    hit     = (data == seq_byte(idx));
    is_af   = (data == 8'hAF);
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    run_n      = run;
    match_n    = 1'b0;
    error_n    = 1'b0;
    seq_done_n = 1'b0;
    if (enable) begin
      unique case (state)
        HUNT: begin
          if (is_af) begin
            idx_n   = 3'd1;
            run_n   = 3'd1;
            state_n = (LOCK_RUN == 3'd1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (hit) begin
            idx_n = idx_inc;
            run_n = run_inc;
            if (run_inc == LOCK_RUN) state_n = LOCKED;
          end else if (is_af) begin
            idx_n = 3'd1;
            run_n = 3'd1;
          end else begin
            state_n = HUNT;
            idx_n   = 3'd0;
            run_n   = 3'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            match_n    = 1'b1;
            seq_done_n = (idx == 3'd6);
            idx_n      = idx_inc;
          end else begin
            error_n = 1'b1;
            // an AF in place of the expected byte is the start of a new frame
            if (is_af) begin
              idx_n   = 3'd1;
              run_n   = 3'd1;
              state_n = (LOCK_RUN == 3'd1) ? LOCKED : SYNC;
            end else begin
              state_n = HUNT;
              idx_n   = 3'd0;
              run_n   = 3'd0;
            end
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = 3'd0;
          run_n   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HUNT;
      idx      <= 3'd0;
      run      <= 3'd0;
      locked   <= 1'b0;
      match    <= 1'b0;
      error    <= 1'b0;
      seq_done <= 1'b0;
      expected <= 8'hAF;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      run      <= run_n;
      locked   <= (state_n == LOCKED);
      match    <= match_n;
      error    <= error_n;
      seq_done <= seq_done_n;
      expected <= seq_byte(idx_n);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
      seq_count <= '0;
    end else if (clr_cnt) begin
      err_count <= '0;
      seq_count <= '0;
    end else begin
      if (error_n && !(&err_count))
        err_count <= err_count + 1'b1;
      if (seq_done_n && !(&seq_count))
        seq_count <= seq_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker (LOCK_LEN=3, CNT_W=2).
// Inputs change 1ns after posedge; outputs are checked 1ns after posedge.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] data;
  logic       clr_cnt;
  logic       locked, match, error, seq_done;
  logic [7:0] expected;
  logic [1:0] err_count, seq_count;

  int n_chk  = 0;
  int n_fail = 0;

  sequence_checker #(.LOCK_LEN(3), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .data      (data),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .match     (match),
    .error     (error),
    .seq_done  (seq_done),
    .expected  (expected),
    .err_count (err_count),
    .seq_count (seq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic l, input logic m,
                      input logic e, input logic sd, input logic [7:0] ex);
    chk({tag, ".locked"},   {7'd0, locked},   {7'd0, l});
    chk({tag, ".match"},    {7'd0, match},    {7'd0, m});
    chk({tag, ".error"},    {7'd0, error},    {7'd0, e});
    chk({tag, ".seq_done"}, {7'd0, seq_done}, {7'd0, sd});
    chk({tag, ".expected"}, expected, ex);
  endtask

  task automatic cnts(input string tag, input logic [1:0] ec,
                      input logic [1:0] sc);
    chk({tag, ".err_count"}, {6'd0, err_count}, {6'd0, ec});
    chk({tag, ".seq_count"}, {6'd0, seq_count}, {6'd0, sc});
  endtask

  task automatic step(input logic [7:0] d, input logic en = 1'b1,
                      input logic clr = 1'b0);
    data    = d;
    enable  = en;
    clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic relock(input string tag);
    step(8'hAF); outs({tag, ".af"}, 0, 0, 0, 0, 8'hBC);
    step(8'hBC); outs({tag, ".bc"}, 0, 0, 0, 0, 8'hE2);
    step(8'hE2); outs({tag, ".e2"}, 1, 0, 0, 0, 8'h78);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    data    = 8'h00;
    clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs("reset", 0, 0, 0, 0, 8'hAF);
    cnts("reset", 0, 0);
    reset_n = 1'b1;

    // 1: acquire lock
    step(8'h11); outs("hunt_junk", 0, 0, 0, 0, 8'hAF);
    relock("t1");

    // 2: full sequence while locked
    step(8'h78); outs("t2.78", 1, 1, 0, 0, 8'hFF);
    step(8'hFF); outs("t2.ff", 1, 1, 0, 0, 8'h0B);
    step(8'h0B); outs("t2.0b", 1, 1, 0, 0, 8'h8D);
    step(8'h8D); outs("t2.8d", 1, 1, 0, 1, 8'hAF);
    cnts("t2.8d", 0, 1);
    step(8'hAF); outs("t2.af", 1, 1, 0, 0, 8'hBC);
    cnts("t2.af", 0, 1);

    // 3: non-AF mismatch drops to HUNT
    step(8'h55); outs("t3.err", 0, 0, 1, 0, 8'hAF);
    cnts("t3.err", 1, 1);
    relock("t3");

    // 4: AF mismatch resyncs directly
    step(8'h78); step(8'hFF); step(8'h0B); step(8'h8D);
    cnts("t4.seq", 1, 2);
    step(8'hAF); step(8'hBC);
    outs("t4.pre", 1, 1, 0, 0, 8'hE2);
    step(8'hAF); outs("t4.err", 0, 0, 1, 0, 8'hBC);
    cnts("t4.err", 2, 2);
    step(8'hBC); outs("t4.bc", 0, 0, 0, 0, 8'hE2);
    step(8'hE2); outs("t4.e2", 1, 0, 0, 0, 8'h78);

    // 5: enable low holds everything
    for (int i = 0; i < 5; i++) begin
      step(8'($urandom), 1'b0);
      outs("t5.hold", 1, 0, 0, 0, 8'h78);
    end
    cnts("t5.hold", 2, 2);
    step(8'h78); outs("t5.resume", 1, 1, 0, 0, 8'hFF);

    // clear coinciding with seq_done
    step(8'hFF); step(8'h0B);
    step(8'h8D, 1'b1, 1'b1); outs("t6.clr", 1, 1, 0, 1, 8'hAF);
    cnts("t6.clr", 0, 0);
    step(8'hAF); cnts("t6.after_clr", 0, 0);

    // SYNC mismatch on non-AF falls back to HUNT silently
    step(8'h00); outs("t6.err1", 0, 0, 1, 0, 8'hAF);
    cnts("t6.err1", 1, 0);
    step(8'hAF); step(8'h12);
    outs("t6.sync_drop", 0, 0, 0, 0, 8'hAF);
    cnts("t6.sync_drop", 1, 0);

    // 6: error counter saturation
    relock("t6a"); step(8'h00); cnts("t6.err2", 2, 0);
    relock("t6b"); step(8'h00); cnts("t6.err3", 3, 0);
    relock("t6c"); step(8'h00);
    outs("t6.err4", 0, 0, 1, 0, 8'hAF);
    cnts("t6.err4", 3, 0);

    // async reset mid-LOCKED, between clock edges
    relock("t6d");
    step(8'h78); outs("t6.prerst", 1, 1, 0, 0, 8'hFF);
    #2 reset_n = 1'b0;
    #1;
    outs("t6.async_rst", 0, 0, 0, 0, 8'hAF);
    cnts("t6.async_rst", 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(8'hAF); outs("t6.post_rst", 0, 0, 0, 0, 8'hBC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
